fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
- Sequences the enable-less 32-bit program counter register. Every cycle it drives that register's next-value input, so holding the PC means feeding the current value back.
- Issues one instruction fetch at a time to a variable-latency instruction memory using a req/ack handshake.
- Presents each fetched instruction to the decode stage and holds it under backpressure.
- Applies branch/jump redirects and vectors to an exception handler on bus error, misaligned PC or fetch timeout.

Parameters:
- N_BITS, 32, PC/address width.
- RESET_PC, 32'h0040_0000, reset value of the PC register; reported as epc_o reset value.
- EXC_VECTOR, 32'h8000_0180, PC loaded on any fetch exception.
- TIMEOUT_CYCLES, 16, cycles in FETCH without ack before a timeout exception; range 2..255.

Ports:
- clk input 1: rising-edge clock.
- reset input 1: asynchronous, active-low reset.
- pc_value_i input N_BITS: current PC register output.
- new_pc_o output N_BITS: next PC, wired to the PC register input (combinational).
- imem_req_o output 1: fetch request.
- imem_addr_o output N_BITS: fetch address.
- imem_ack_i input 1: fetch complete, data valid this cycle.
- imem_err_i input 1: fetch bus error, qualified with imem_ack_i.
- imem_rdata_i input 32: fetched instruction word.
- instr_o output 32: instruction to decode.
- instr_pc_o output N_BITS: PC of instr_o.
- instr_valid_o output 1: instr_o valid.
- stall_i input 1: decode cannot accept this cycle.
- branch_taken_i input 1: redirect for the instruction being consumed.
- branch_target_i input N_BITS: redirect target.
- exc_o output 1: one-cycle exception pulse.
- exc_cause_o output 2: 0 none, 1 bus error, 2 misaligned, 3 timeout.
- epc_o output N_BITS: PC of faulting fetch.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to BOOT; all registered outputs clear: instr_o=0, instr_pc_o=0, instr_valid_o=0, exc_o=0, exc_cause_o=0, epc_o=RESET_PC, timeout counter=0.
  - imem_req_o drops immediately, including mid-fetch; any in-flight ack after reset release is ignored until the next FETCH.
- new_pc_o defaults to pc_value_i (hold) in every state unless stated otherwise.
- BOOT: no request; next state FETCH.
- FETCH:
  - imem_addr_o=pc_value_i.
  - If pc_value_i[1:0]!=0: imem_req_o=0, next state EXC with cause 2.
  - Otherwise imem_req_o=1 until the ack cycle, inclusive.
  - Ack with imem_err_i=0: latch instr_o=imem_rdata_i and instr_pc_o=pc_value_i; set instr_valid_o=1 at the same edge; new_pc_o=pc_value_i+4 (mod 2^N_BITS, wraps 32'hFFFF_FFFC to 0); next state HOLD.
  - Ack with imem_err_i=1: error wins; data discarded; next state EXC with cause 1.
  - Timeout: counter increments each FETCH cycle without ack and clears on entry to FETCH. When it reaches TIMEOUT_CYCLES-1 with no ack, go to EXC with cause 3. An ack in that same cycle wins over the timeout.
- HOLD:
  - instr_valid_o=1, instr_o stable; ack/err ignored.
  - stall_i=1: hold state and outputs; branch_taken_i ignored.
  - stall_i=0: instruction consumed at this edge and instr_valid_o clears. If branch_taken_i=1, new_pc_o=branch_target_i; otherwise hold (PC already +4). Next state FETCH.
- EXC:
  - new_pc_o=EXC_VECTOR; epc_o and exc_cause_o latched on entry.
  - exc_o=1 for exactly this one cycle; exc_cause_o holds until the next exception or reset.
  - instr_valid_o=0; next state FETCH.
- Misaligned branch targets are reported on the next FETCH (cause 2, epc = target).
- Throughput: minimum 2 cycles per instruction (1-cycle ack + unstalled HOLD).

Test Plan:
- Reset then release; memory acks in 1 cycle with 32'h2008_0005 → BOOT 1 cycle; req at 32'h0040_0000; instr_valid_o=1 with instr_pc_o=32'h0040_0000; PC becomes 32'h0040_0004.
- stall_i=1 for 3 cycles during HOLD with branch_taken_i=1 pulsed → instr_o unchanged, PC held at 32'h0040_0004, branch ignored; on release the next fetch is at 32'h0040_0004.
- Unstalled consume with branch_taken_i=1 and target 32'h0040_0020 → next imem_addr_o=32'h0040_0020.
- Ack and err together at PC 32'h0040_0008 → exc_o pulse, exc_cause_o=1, epc_o=32'h0040_0008, next fetch at 32'h8000_0180, instr_valid_o never set.
- Branch to 32'h0040_0012 → no request issued, exc_cause_o=2, epc_o=32'h0040_0012; memory never acks after that → cause 3 after 16 FETCH cycles at 32'h8000_0180.
- reset asserted 2 cycles into an outstanding fetch → imem_req_o falls asynchronously, outputs at reset values, late ack ignored, refetch starts at 32'h0040_0000.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: drives the next-PC input of an external PC register, issues
// one req/ack instruction fetch at a time, holds the fetched word for decode
// under backpressure, and redirects on branches and fetch exceptions.
module fetch_sequencer #(
    parameter int unsigned          N_BITS         = 32,
    parameter logic [N_BITS-1:0]    RESET_PC       = 32'h0040_0000,
    parameter logic [N_BITS-1:0]    EXC_VECTOR     = 32'h8000_0180,
    parameter int unsigned          TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_BITS-1:0] pc_value_i,
    output logic [N_BITS-1:0] new_pc_o,
    output logic              imem_req_o,
    output logic [N_BITS-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic              imem_err_i,
    input  logic [31:0]       imem_rdata_i,
    output logic [31:0]       instr_o,
    output logic [N_BITS-1:0] instr_pc_o,
    output logic              instr_valid_o,
    input  logic              stall_i,
    input  logic              branch_taken_i,
    input  logic [N_BITS-1:0] branch_target_i,
    output logic              exc_o,
    output logic [1:0]        exc_cause_o,
    output logic [N_BITS-1:0] epc_o
);

    localparam int unsigned       CNT_W    = 8;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [N_BITS-1:0] PC_STEP  = N_BITS'(4);

    localparam logic [1:0] CAUSE_BUS   = 2'd1;
    localparam logic [1:0] CAUSE_ALIGN = 2'd2;
    localparam logic [1:0] CAUSE_TMO   = 2'd3;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_EXC   = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        instr_q, instr_d;
    logic [N_BITS-1:0]  instr_pc_q, instr_pc_d;
    logic               valid_q, valid_d;
    logic               exc_q, exc_d;
    logic [1:0]         cause_q, cause_d;
    logic [N_BITS-1:0]  epc_q, epc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    assign instr_o       = instr_q;
    assign instr_pc_o    = instr_pc_q;
    assign instr_valid_o = valid_q;
    assign exc_o         = exc_q;
    assign exc_cause_o   = cause_q;
    assign epc_o         = epc_q;

    // Next-state, next-PC and fetch request; request is decoded from state so
    // it drops the moment reset forces the state back to BOOT.
    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        instr_pc_d  = instr_pc_q;
        valid_d     = valid_q;
        exc_d       = 1'b0;
        cause_d     = cause_q;
        epc_d       = epc_q;
        cnt_d       = cnt_q;
        new_pc_o    = pc_value_i;
        imem_req_o  = 1'b0;
        imem_addr_o = pc_value_i;

        unique case (state_q)
            S_BOOT: begin
                valid_d = 1'b0;
                cnt_d   = '0;
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (pc_value_i[1:0] != 2'b00) begin
                    exc_d   = 1'b1;
                    cause_d = CAUSE_ALIGN;
                    epc_d   = pc_value_i;
                    state_d = S_EXC;
                end else begin
                    imem_req_o = 1'b1;
                    if (imem_ack_i) begin
                        if (imem_err_i) begin
                            exc_d   = 1'b1;
                            cause_d = CAUSE_BUS;
                            epc_d   = pc_value_i;
                            state_d = S_EXC;
                        end else begin
                            instr_d    = imem_rdata_i;
                            instr_pc_d = pc_value_i;
                            valid_d    = 1'b1;
                            new_pc_o   = pc_value_i + PC_STEP;
                            state_d    = S_HOLD;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        exc_d   = 1'b1;
                        cause_d = CAUSE_TMO;
                        epc_d   = pc_value_i;
                        state_d = S_EXC;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_HOLD: begin
                if (!stall_i) begin
                    valid_d = 1'b0;
                    cnt_d   = '0;
                    state_d = S_FETCH;
                    if (branch_taken_i) begin
                        new_pc_o = branch_target_i;
                    end
                end
            end
            S_EXC: begin
                new_pc_o = EXC_VECTOR;
                valid_d  = 1'b0;
                cnt_d    = '0;
                state_d  = S_FETCH;
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_BOOT;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            exc_q      <= 1'b0;
            cause_q    <= '0;
            epc_q      <= RESET_PC;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            exc_q      <= exc_d;
            cause_q    <= cause_d;
            epc_q      <= epc_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule
